// File: rtl/conv_pkg.sv
// Shared types for the convolution input path.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/memory.sv
// Single-port RAM: synchronous write, registered read (one cycle latency).
module memory #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SIZE  = 16,
  localparam int unsigned AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rdata_q;

  // Storage is never reset; contents are valid only after a reload.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/input_mem_ctrl.sv
// Loads filter W and input matrix X from an AXI-stream into local RAMs and
// holds them readable for the datapath until it signals compute_finished.
module input_mem_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned INW   = 12,
  parameter int unsigned R     = 9,
  parameter int unsigned C     = 8,
  parameter int unsigned MAXK  = 4,
  localparam int unsigned XADDR = $clog2(R*C),
  localparam int unsigned WADDR = $clog2(MAXK*MAXK),
  localparam int unsigned KBITS = $clog2(MAXK+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INW-1:0]     AXIS_TDATA,
  input  logic               AXIS_TVALID,
  input  logic [KBITS:0]     AXIS_TUSER,
  output logic               AXIS_TREADY,
  output logic               inputs_loaded,
  input  logic               compute_finished,
  output logic [KBITS-1:0]   K,
  input  logic [XADDR-1:0]   X_read_addr,
  output logic [INW-1:0]     X_data,
  input  logic [WADDR-1:0]   W_read_addr,
  output logic [INW-1:0]     W_data
);

  // Wide enough for K*K and counter+1 without wrapping.
  localparam int unsigned CW = 2*KBITS + WADDR + 2;

  state_e            state_q, state_d;
  logic [WADDR-1:0]  wcnt_q, wcnt_d;
  logic [XADDR-1:0]  xcnt_q, xcnt_d;
  logic [KBITS-1:0]  k_q, k_d;
  logic              w_we_c, x_we_c;
  logic              hs_c, new_w_c, kk_one_c, w_last_c, x_last_c;
  logic [KBITS-1:0]  tuser_k_c;
  logic [XADDR-1:0]  x_addr_c;
  logic [WADDR-1:0]  w_addr_c;

  // Handshake and terminal-count decodes.
  assign hs_c      = AXIS_TVALID & AXIS_TREADY;
  assign new_w_c   = AXIS_TUSER[0];
  assign tuser_k_c = AXIS_TUSER[KBITS:1];
  assign kk_one_c  = (CW'(tuser_k_c) * CW'(tuser_k_c)) == CW'(1);
  assign w_last_c  = (CW'(wcnt_q) + CW'(1)) == (CW'(k_q) * CW'(k_q));
  assign x_last_c  = 32'(xcnt_q) == (R*C - 1);

  // State, counters and K register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      xcnt_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      xcnt_q  <= xcnt_d;
      k_q     <= k_d;
    end
  end

  // Next-state, counter advance and write enables.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    xcnt_d  = xcnt_q;
    k_d     = k_q;
    w_we_c  = 1'b0;
    x_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_c) begin
          if (new_w_c) begin
            k_d    = tuser_k_c;
            w_we_c = 1'b1;
            if (kk_one_c) begin
              state_d = LOAD_X;
              wcnt_d  = '0;
              xcnt_d  = '0;
            end else begin
              state_d = LOAD_W;
              wcnt_d  = WADDR'(1);
            end
          end else begin
            x_we_c  = 1'b1;
            xcnt_d  = XADDR'(1);
            state_d = LOAD_X;
          end
        end
      end
      LOAD_W: begin
        if (hs_c) begin
          w_we_c = 1'b1;
          if (w_last_c) begin
            state_d = LOAD_X;
            wcnt_d  = '0;
            xcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WADDR'(1);
          end
        end
      end
      LOAD_X: begin
        if (hs_c) begin
          x_we_c = 1'b1;
          if (x_last_c) begin
            state_d = DONE;
            xcnt_d  = '0;
          end else begin
            xcnt_d = xcnt_q + XADDR'(1);
          end
        end
      end
      DONE: begin
        if (compute_finished) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath reads in DONE, loader writes otherwise.
  assign x_addr_c = (state_q == DONE) ? X_read_addr : xcnt_q;
  assign w_addr_c = (state_q == DONE) ? W_read_addr : wcnt_q;

  assign AXIS_TREADY   = (state_q != DONE);
  assign inputs_loaded = (state_q == DONE);
  assign K             = k_q;

  memory #(.WIDTH(INW), .SIZE(R*C)) u_x_mem (
    .clk     (clk),
    .we_i    (x_we_c),
    .addr_i  (x_addr_c),
    .wdata_i (AXIS_TDATA),
    .rdata_o (X_data)
  );

  memory #(.WIDTH(INW), .SIZE(MAXK*MAXK)) u_w_mem (
    .clk     (clk),
    .we_i    (w_we_c),
    .addr_i  (w_addr_c),
    .wdata_i (AXIS_TDATA),
    .rdata_o (W_data)
  );

endmodule

// File: tb/tb_input_mem_ctrl.sv
// Self-checking bench for input_mem_ctrl with a destination-list reference model.
module tb_input_mem_ctrl;

  localparam int unsigned INW   = 12;
  localparam int unsigned R     = 9;
  localparam int unsigned C     = 8;
  localparam int unsigned MAXK  = 4;
  localparam int unsigned XADDR = 7;
  localparam int unsigned WADDR = 4;
  localparam int unsigned KBITS = 3;
  localparam int          NX    = R*C;

  logic              clk = 1'b0;
  logic              reset;
  logic [INW-1:0]    AXIS_TDATA;
  logic              AXIS_TVALID;
  logic [KBITS:0]    AXIS_TUSER;
  logic              AXIS_TREADY;
  logic              inputs_loaded;
  logic              compute_finished;
  logic [KBITS-1:0]  K;
  logic [XADDR-1:0]  X_read_addr;
  logic [INW-1:0]    X_data;
  logic [WADDR-1:0]  W_read_addr;
  logic [INW-1:0]    W_data;

  always #5 clk = ~clk;

  input_mem_ctrl #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TUSER       (AXIS_TUSER),
    .AXIS_TREADY      (AXIS_TREADY),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .K                (K),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a load is a list of destinations; each handshake fills the next one.
  int unsigned m_w [MAXK*MAXK];
  int unsigned m_x [NX];
  int          m_k = 0;
  bit          m_loaded = 1'b0;
  int          m_q [$];
  int          hs_count = 0;

  typedef struct {
    bit          is_x;
    int          addr;
    int unsigned exp;
  } rd_vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int d;
    if (reset) begin
      m_loaded = 1'b0;
      m_k      = 0;
      m_q.delete();
    end else if (m_loaded) begin
      if (compute_finished) m_loaded = 1'b0;
    end else if (AXIS_TVALID) begin
      hs_count++;
      if (m_q.size() == 0) begin
        if (AXIS_TUSER[0]) begin
          m_k = int'(AXIS_TUSER[KBITS:1]);
          for (int i = 0; i < m_k*m_k; i++) m_q.push_back(1000 + i);
        end
        for (int i = 0; i < NX; i++) m_q.push_back(i);
      end
      d = m_q.pop_front();
      if (d >= 1000) m_w[d-1000] = int'(AXIS_TDATA);
      else           m_x[d]      = int'(AXIS_TDATA);
      if (m_q.size() == 0) m_loaded = 1'b1;
    end
  endtask

  // One clock: update the model at the edge, then compare status outputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tready", 32'(AXIS_TREADY), m_loaded ? 0 : 1);
    check("inputs_loaded", 32'(inputs_loaded), 32'(m_loaded));
    check("K", 32'(K), m_k);
  endtask

  task automatic read_check(input bit is_x, input int addr, input int unsigned exp);
    if (is_x) X_read_addr = XADDR'(addr);
    else      W_read_addr = WADDR'(addr);
    step();
    if (is_x) check("X_data", 32'(X_data), exp);
    else      check("W_data", 32'(W_data), exp);
  endtask

  // Streams words until the model reports loaded (or max_hs handshakes are made).
  task automatic drive_load(input bit new_w, input int k, input int gap_pct,
                            input bit seq, input int base, input int max_hs,
                            input bit cf_noise);
    int start = hs_count;
    int cycles = 0;
    bit first;
    while (!m_loaded && (hs_count - start) < max_hs && cycles < 3000) begin
      first = (m_q.size() == 0);
      AXIS_TVALID      = ($urandom_range(99) >= gap_pct);
      AXIS_TDATA       = seq ? INW'(base + hs_count - start) : INW'($urandom);
      AXIS_TUSER       = first ? {KBITS'(k), new_w} : (KBITS+1)'($urandom);
      compute_finished = cf_noise ? ($urandom_range(5) == 0) : 1'b0;
      step();
      cycles++;
    end
    AXIS_TVALID      = 1'b0;
    compute_finished = 1'b0;
    if (cycles >= 3000) check("load_timeout", 0, 1);
  endtask

  task automatic release_mem();
    compute_finished = 1'b1;
    step();
    compute_finished = 1'b0;
  endtask

  rd_vec_t full_tbl[6];
  rd_vec_t reuse_tbl[5];

  initial begin
    int start;
    int k;
    bit nw;
    full_tbl = '{'{1'b0, 4, 5}, '{1'b1, 0, 10}, '{1'b0, 0, 1},
                 '{1'b0, 8, 9}, '{1'b1, 71, 81}, '{1'b1, 35, 45}};
    reuse_tbl = '{'{1'b0, 8, 9}, '{1'b1, 71, 171}, '{1'b1, 0, 100},
                  '{1'b0, 4, 5}, '{1'b1, 40, 140}};

    reset = 1'b1; AXIS_TVALID = 1'b0; AXIS_TDATA = '0; AXIS_TUSER = '0;
    compute_finished = 1'b0; X_read_addr = '0; W_read_addr = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_tready", 32'(AXIS_TREADY), 1);
    check("reset_K", 32'(K), 0);

    // Full load: words 1..81, K=3.
    start = hs_count;
    drive_load(1'b1, 3, 0, 1'b1, 1, 1000, 1'b0);
    check("full_hs", hs_count - start, 81);
    check("full_loaded", 32'(inputs_loaded), 1);
    check("full_tready", 32'(AXIS_TREADY), 0);
    check("full_K", 32'(K), 3);
    foreach (full_tbl[i]) begin
      read_check(full_tbl[i].is_x, full_tbl[i].addr, full_tbl[i].exp);
      check("full_model", full_tbl[i].is_x ? m_x[full_tbl[i].addr] : m_w[full_tbl[i].addr],
            full_tbl[i].exp);
    end

    // Release in DONE, then reuse W: 100..171, K field of first word must be ignored.
    release_mem();
    check("release_loaded", 32'(inputs_loaded), 0);
    check("release_tready", 32'(AXIS_TREADY), 1);
    start = hs_count;
    drive_load(1'b0, 1, 0, 1'b1, 100, 1000, 1'b1);
    check("reuse_hs", hs_count - start, 72);
    check("reuse_K", 32'(K), 3);
    foreach (reuse_tbl[i]) read_check(reuse_tbl[i].is_x, reuse_tbl[i].addr, reuse_tbl[i].exp);

    // K=2 load with random valid gaps.
    release_mem();
    start = hs_count;
    drive_load(1'b1, 2, 40, 1'b0, 0, 1000, 1'b1);
    check("gap_hs", hs_count - start, 4 + 72);
    for (int i = 0; i < 4; i++)  read_check(1'b0, i, m_w[i]);
    for (int i = 0; i < NX; i++) read_check(1'b1, i, m_x[i]);

    // Reset after 30 X handshakes, then a fresh K=4 load.
    release_mem();
    drive_load(1'b0, 0, 20, 1'b0, 0, 30, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_tready", 32'(AXIS_TREADY), 1);
    check("midreset_loaded", 32'(inputs_loaded), 0);
    check("midreset_K", 32'(K), 0);
    start = hs_count;
    drive_load(1'b1, 4, 30, 1'b0, 0, 1000, 1'b1);
    check("k4_hs", hs_count - start, 16 + 72);
    for (int i = 0; i < 16; i++) read_check(1'b0, i, m_w[i]);

    // Random loads, including K=1.
    for (int r = 0; r < 5; r++) begin
      release_mem();
      k  = (r == 0) ? 1 : int'($urandom_range(1, 4));
      nw = (r == 0) ? 1'b1 : 1'b1 & $urandom;
      start = hs_count;
      drive_load(nw, k, 25, 1'b0, 0, 1000, 1'b1);
      check("rand_hs", hs_count - start, (nw ? k*k : 0) + 72);
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(1) == 0) begin
          k = int'($urandom_range(m_k*m_k - 1));
          read_check(1'b0, k, m_w[k]);
        end else begin
          k = int'($urandom_range(NX - 1));
          read_check(1'b1, k, m_x[k]);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_mem_ctrl.md
INPUT_MEM_CTRL -- requirements
Module: input_mem_ctrl

Interface
REQ-001 SHALL have parameter INW, default 12: data word width in bits.
REQ-002 SHALL have parameter R, default 9: input matrix X rows.
REQ-003 SHALL have parameter C, default 8: input matrix X columns.
REQ-004 SHALL have parameter MAXK, default 4: maximum filter W dimension.
REQ-005 SHALL have derived localparams:
- XADDR = $clog2(R*C)
- WADDR = $clog2(MAXK*MAXK)
- KBITS = $clog2(MAXK+1)
REQ-006 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port AXIS_TDATA, input, INW bits: streamed input word.
REQ-009 SHALL have port AXIS_TVALID, input, 1 bit: upstream word valid.
REQ-010 SHALL have port AXIS_TUSER, input, KBITS+1 bits: bit0 = new_W; bits [KBITS:1] = K.
REQ-011 SHALL have port AXIS_TREADY, output, 1 bit: block accepts a word.
REQ-012 SHALL have port inputs_loaded, output, 1 bit: W and X are resident and readable.
REQ-013 SHALL have port compute_finished, input, 1 bit: datapath releases the memories.
REQ-014 SHALL have port K, output, KBITS bits: current filter dimension.
REQ-015 SHALL have port X_read_addr, input, XADDR bits: X read address, row-major.
REQ-016 SHALL have port X_data, output, INW bits: X read data.
REQ-017 SHALL have port W_read_addr, input, WADDR bits: W read address, row-major.
REQ-018 SHALL have port W_data, output, INW bits: W read data.

Function
REQ-019 SHALL define a handshake as AXIS_TVALID & AXIS_TREADY on a rising edge; only handshakes write words or advance counters.
REQ-020 SHALL implement FSM states IDLE, LOAD_W, LOAD_X, DONE.
REQ-021 SHALL drive AXIS_TREADY=1 in IDLE, LOAD_W and LOAD_X, and 0 in DONE.
REQ-022 SHALL, on a handshake in IDLE with new_W=1, latch K from TUSER, write the word to W[0], and go to LOAD_W with the W counter at 1.
- Exception: if K*K==1, go directly to LOAD_X.
REQ-023 SHALL, on a handshake in IDLE with new_W=0, keep K and W unchanged, write the word to X[0], and go to LOAD_X with the X counter at 1.
REQ-024 SHALL, in LOAD_W, write each handshake word to W[wcnt]; the handshake at wcnt==K*K-1 goes to LOAD_X with the X counter at 0.
REQ-025 SHALL, in LOAD_X, write each handshake word to X[xcnt]; the handshake at xcnt==R*C-1 goes to DONE.
REQ-026 SHALL ignore TUSER on every handshake other than the first word in IDLE.
REQ-027 SHALL assert inputs_loaded combinationally from state==DONE, i.e. in the cycle after the final X handshake.
REQ-028 SHALL route memory addresses as follows:
- In DONE: X_read_addr and W_read_addr.
- Otherwise: the write counters.
- Write enable is asserted only on handshakes in the matching load state.
REQ-029 SHALL provide X_data and W_data exactly one cycle after the address is presented; there is no other read latency.
REQ-030 SHALL, on compute_finished=1 in DONE, go to IDLE on the next edge; AXIS_TREADY=1 that same following cycle.
REQ-031 SHALL ignore compute_finished in every state other than DONE.
REQ-032 SHALL compute the comparisons K*K-1 and R*C-1 at full width without overflow for K up to MAXK.

Reset
REQ-033 SHALL, on reset=1 at a rising edge (taking priority over all events, including mid-load), set:
- state = IDLE
- both counters = 0
- K = 0
- inputs_loaded = 0
- AXIS_TREADY = 1 in the following cycle
REQ-034 SHALL NOT clear memory contents on reset; W and X are undefined until reloaded.
REQ-035 SHALL require upstream to send new_W=1 as the first transfer after reset; behaviour otherwise is unspecified beyond using K=0.

Structure
REQ-036 SHALL place the state enum (IDLE, LOAD_W, LOAD_X, DONE) in shared package conv_pkg.
REQ-037 SHALL instantiate sub-module memory twice:
- X store: WIDTH=INW, SIZE=R*C.
- W store: WIDTH=INW, SIZE=MAXK*MAXK.

Verification (R=9, C=8, MAXK=4)
REQ-038 SHALL cover full load: reset, then words 1..81 with new_W=1 and K=3 on the first word.
- inputs_loaded=1 the cycle after handshake 81, AXIS_TREADY=0.
- K=3.
- W_read_addr=4 gives W_data=5 the next cycle.
- X_read_addr=0 gives X_data=10 the next cycle.
REQ-039 SHALL cover reuse of W: after compute_finished, send 72 words 100..171 with new_W=0.
- K stays 3.
- W_data at address 8 is 9.
- X_data at address 71 is 171.
REQ-040 SHALL cover valid gaps: TVALID deasserted on random cycles during a K=2 load.
- Exactly 4+72 handshakes reach DONE; no gap cycle writes.
REQ-041 SHALL cover compute_finished placement.
- Pulsed in LOAD_X: no effect.
- Pulsed in DONE: next cycle state IDLE, inputs_loaded=0, AXIS_TREADY=1.
REQ-042 SHALL cover reset mid-load: reset after 30 X handshakes.
- Next cycle: IDLE, K=0, inputs_loaded=0.
- A fresh K=4 load needs 16+72 handshakes to reach DONE.
